// File: rtl/pc_flag_ctrl_if.sv
// Decoder/ALU-to-PC-controller bundle: instruction fields and ALU results in,
// fetch address, flags and branch status out.
interface pc_flag_ctrl_if;
  logic        En;
  logic [3:0]  Opcode;
  logic [2:0]  Cond;
  logic [8:0]  Imm9;
  logic [15:0] Reg_Target;
  logic [15:0] ALU_Result;
  logic [2:0]  Flags_in;
  logic [15:0] PC_out;
  logic [15:0] PC_plus2;
  logic [2:0]  Flags_q;
  logic        Branch_taken;
  logic        Halted;

  modport master (
    output En, Opcode, Cond, Imm9, Reg_Target, ALU_Result, Flags_in,
    input  PC_out, PC_plus2, Flags_q, Branch_taken, Halted
  );

  modport slave (
    input  En, Opcode, Cond, Imm9, Reg_Target, ALU_Result, Flags_in,
    output PC_out, PC_plus2, Flags_q, Branch_taken, Halted
  );
endinterface

// File: rtl/pc_flag_ctrl.sv
// Program counter and N/V/Z flag register for the 16-bit single-cycle core:
// flag capture, branch evaluation against registered flags, and HLT handling.
module pc_flag_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_flag_ctrl_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic [15:0] imm_off;
  logic        flag_n, flag_v, flag_z;
  logic        cond_true;
  logic        is_branch;
  logic        branch_taken;

  // N and Z of the incoming ALU flags are recomputed locally from ALU_Result.
  logic unused_flag_bits;
  assign unused_flag_bits = ^{bus.Flags_in[2], bus.Flags_in[0]};

  assign flag_n = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_z = flags_q[0];

  always_comb begin
    pc_plus2 = pc_q + 16'd2;
    imm_off  = {{6{bus.Imm9[8]}}, bus.Imm9, 1'b0};

    cond_true = 1'b0;
    case (bus.Cond)
      3'b000:  cond_true = !flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z && !flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_true = flag_n || flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase

    is_branch    = (bus.Opcode == OP_B) || (bus.Opcode == OP_BR);
    branch_taken = (state_q == RUN) && is_branch && cond_true;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    halted_d = halted_q;

    if (state_q == RUN && bus.En) begin
      if (bus.Opcode == OP_HLT) begin
        // PC stays on the HLT address so the halt point is visible.
        state_d  = HALT;
        halted_d = 1'b1;
      end else begin
        if (branch_taken) begin
          pc_d = (bus.Opcode == OP_BR) ? bus.Reg_Target : pc_plus2 + imm_off;
        end else begin
          pc_d = pc_plus2;
        end

        case (bus.Opcode)
          OP_ADD, OP_SUB: begin
            flags_d = {bus.ALU_Result[15], bus.Flags_in[1], (bus.ALU_Result == 16'h0000)};
          end
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
            flags_d[0] = (bus.ALU_Result == 16'h0000);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      flags_q  <= 3'b000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign bus.PC_out       = pc_q;
  assign bus.PC_plus2     = pc_plus2;
  assign bus.Flags_q      = flags_q;
  assign bus.Branch_taken = branch_taken;
  assign bus.Halted       = halted_q;

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Directed bench for pc_flag_ctrl: reset, flags, every branch condition,
// wrap-around, stall, halt and same-cycle flag/branch ordering.
module tb_pc_flag_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [7:0] taken_mask;

  pc_flag_ctrl_if bus ();

  pc_flag_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] op, input logic [2:0] cnd,
                       input logic [8:0] imm, input logic [15:0] tgt,
                       input logic [15:0] alu, input logic [2:0] fin);
    bus.En         = en;
    bus.Opcode     = op;
    bus.Cond       = cnd;
    bus.Imm9       = imm;
    bus.Reg_Target = tgt;
    bus.ALU_Result = alu;
    bus.Flags_in   = fin;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 4'b0000, 3'b000, 9'h000, 16'h0000, 16'h0005, 3'b000);
    step();
    check("reset_pc", bus.PC_out, 16'h0000);
    check("reset_flags", {13'd0, bus.Flags_q}, 16'h0000);
    check("reset_halted", {15'd0, bus.Halted}, 16'h0000);
    rst = 1'b0;

    step();
    check("seq_pc_2", bus.PC_out, 16'h0002);
    step();
    check("seq_pc_4", bus.PC_out, 16'h0004);
    check("seq_plus2", bus.PC_plus2, 16'h0006);
    check("seq_halted", {15'd0, bus.Halted}, 16'h0000);

    drive(1'b1, 4'b0001, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b010);
    step();
    check("sub_flags", {13'd0, bus.Flags_q}, 16'h0003);
    drive(1'b1, 4'b0011, 3'b000, 9'h000, 16'h0000, 16'h8001, 3'b000);
    step();
    check("xor_flags", {13'd0, bus.Flags_q}, 16'h0002);
    drive(1'b1, 4'b1000, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b111);
    step();
    check("lw_flags", {13'd0, bus.Flags_q}, 16'h0002);
    check("lw_pc", bus.PC_out, 16'h000A);

    drive(1'b1, 4'b0000, 3'b000, 9'h000, 16'h0000, 16'h8000, 3'b000);
    step();
    check("add_neg_flags", {13'd0, bus.Flags_q}, 16'h0004);

    // Flags N=1,V=0,Z=0: NE, LT, LE, UNCOND taken (conds 0,3,5,7).
    taken_mask = 8'b1010_1001;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 4'b1101, 3'b111, 9'h000, 16'h0010, 16'h0000, 3'b000);
      step();
      check("br_to_0010", bus.PC_out, 16'h0010);
      drive(1'b1, 4'b1100, 3'(c), 9'h1FC, 16'h0000, 16'h0000, 3'b000);
      check($sformatf("cond%0d_taken", c), {15'd0, bus.Branch_taken}, {15'd0, taken_mask[c]});
      step();
      check($sformatf("cond%0d_pc", c), bus.PC_out, taken_mask[c] ? 16'h000A : 16'h0012);
    end
    check("flags_after_branches", {13'd0, bus.Flags_q}, 16'h0004);

    drive(1'b1, 4'b1101, 3'b111, 9'h000, 16'h1234, 16'h0000, 3'b000);
    step();
    check("br_1234", bus.PC_out, 16'h1234);
    drive(1'b1, 4'b1101, 3'b111, 9'h000, 16'hFFFE, 16'h0000, 3'b000);
    step();
    drive(1'b1, 4'b1000, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    check("wrap_plus2", bus.PC_plus2, 16'h0000);
    step();
    check("wrap_seq", bus.PC_out, 16'h0000);
    drive(1'b1, 4'b1101, 3'b111, 9'h000, 16'hFFFC, 16'h0000, 3'b000);
    step();
    drive(1'b1, 4'b1100, 3'b111, 9'h002, 16'h0000, 16'h0000, 3'b000);
    step();
    check("wrap_branch", bus.PC_out, 16'h0002);

    drive(1'b0, 4'b0000, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b010);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.PC_out, 16'h0002);
      check("stall_flags", {13'd0, bus.Flags_q}, 16'h0004);
    end
    check("stall_plus2", bus.PC_plus2, 16'h0004);

    // SUB sets Z, then B EQ must see the freshly registered Z.
    drive(1'b1, 4'b0001, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    step();
    check("sub_z_flags", {13'd0, bus.Flags_q}, 16'h0001);
    drive(1'b1, 4'b1100, 3'b001, 9'h002, 16'h0000, 16'h0000, 3'b000);
    check("beq_after_sub_taken", {15'd0, bus.Branch_taken}, 16'h0001);
    step();
    check("beq_after_sub_pc", bus.PC_out, 16'h000A);

    drive(1'b1, 4'b0000, 3'b000, 9'h000, 16'h0000, 16'h0001, 3'b000);
    step();
    drive(1'b1, 4'b1100, 3'b001, 9'h002, 16'h0000, 16'h0000, 3'b000);
    check("no_alu_bypass_taken", {15'd0, bus.Branch_taken}, 16'h0000);
    step();
    check("no_alu_bypass_pc", bus.PC_out, 16'h000E);
    check("no_alu_bypass_flags", {13'd0, bus.Flags_q}, 16'h0000);

    drive(1'b1, 4'b1101, 3'b111, 9'h000, 16'h0020, 16'h0000, 3'b000);
    step();
    drive(1'b1, 4'b1111, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    check("pre_hlt_halted", {15'd0, bus.Halted}, 16'h0000);
    step();
    check("hlt_halted", {15'd0, bus.Halted}, 16'h0001);
    check("hlt_pc", bus.PC_out, 16'h0020);
    for (int i = 0; i < 12; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'b111, 9'($urandom),
            16'($urandom), 16'($urandom), 3'($urandom));
      check("halt_no_branch", {15'd0, bus.Branch_taken}, 16'h0000);
      step();
      check("halt_pc_hold", bus.PC_out, 16'h0020);
      check("halt_flag_hold", {13'd0, bus.Flags_q}, 16'h0000);
      check("halt_hold", {15'd0, bus.Halted}, 16'h0001);
    end

    rst = 1'b1;
    drive(1'b0, 4'b1111, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    step();
    rst = 1'b0;
    check("rst_after_halt_pc", bus.PC_out, 16'h0000);
    check("rst_after_halt_halted", {15'd0, bus.Halted}, 16'h0000);
    step();
    check("hlt_stalled_halted", {15'd0, bus.Halted}, 16'h0000);
    check("hlt_stalled_pc", bus.PC_out, 16'h0000);
    drive(1'b1, 4'b1111, 3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    step();
    check("hlt_retire_halted", {15'd0, bus.Halted}, 16'h0001);
    check("hlt_retire_pc", bus.PC_out, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_flag_ctrl.md
Name: pc_flag_ctrl

Overview:
- Consumer side of the ALU result/flag interface. Holds the architectural N/V/Z flag register and the program counter for the 16-bit single-cycle core.
- Each cycle it does three things:
  - captures flags from the ALU for flag-setting opcodes;
  - evaluates branch conditions against the registered flags;
  - computes the next PC for sequential, B, BR and HLT flow.
- Sits between the ALU outputs, the decoder and instruction-fetch address.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- En  in  1  advance enable. 0 = stall: PC, flags and state all hold.
- Opcode  in  4  current instruction opcode; same encoding as the ALU (B=1100, BR=1101, PCS=1110, HLT=1111).
- Cond  in  3  branch condition field.
- Imm9  in  9  signed branch offset, in instruction words.
- Reg_Target  in  16  Rs value for BR.
- ALU_Result  in  16  ALU output for the current instruction.
- Flags_in  in  3  ALU flags {N,V,Z}; only bit 1 (V) is consumed.
- PC_out  out  16  current PC, the fetch address.
- PC_plus2  out  16  PC_out+2, combinational; the PCS writeback value.
- Flags_q  out  3  registered {N,V,Z}.
- Branch_taken  out  1  combinational; 1 when the current B/BR redirects.
- Halted  out  1  registered; 1 once HLT has retired.

Behaviour:
- Reset, checked on rising edge with rst=1 regardless of En:
  - PC_out=RESET_PC, Flags_q=3'b000, state=RUN, Halted=0.
  - Reset mid-branch or mid-halt fully discards pending flow.
- States:
  - RUN:
    - En=1 and Opcode=HLT -> HALT; PC holds at the HLT address.
    - Otherwise PC<=PC_next when En=1.
  - HALT:
    - PC, flags and Halted=1 hold until rst; all inputs are ignored.
    - Halted goes to 1 on the same edge as the transition into HALT.
- Flag update, on the edge with En=1 in RUN:
  - ADD(0000), SUB(0001): N<=ALU_Result[15], V<=Flags_in[1], Z<=(ALU_Result==0).
  - XOR, SLL, SRA, ROR (0011-0110): Z<=(ALU_Result==0); N and V hold.
  - All other opcodes: flags hold.
- Branch conditions always use Flags_q, the value before the current instruction. No bypass from ALU_Result.
  - 000 NE: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 and N==0
  - 011 LT: N==1
  - 100 GE: Z==1 or (Z==0 and N==0)
  - 101 LE: N==1 or Z==1
  - 110 OV: V==1
  - 111 UNCOND: always true
- Branch_taken = (Opcode is B or BR) and condition true and state==RUN. Forced to 0 in HALT.
- PC_next:
  - B taken: PC_plus2 + (sext(Imm9)<<1).
  - BR taken: Reg_Target.
  - Otherwise: PC_plus2.
- Arithmetic:
  - Modulo 2^16; wrap-around is silent (e.g. PC 16'hFFFE -> 16'h0000).
  - Imm9 is sign-extended to 16 bits before the shift.
  - Bit 0 of every PC value is not forced; the decoder guarantees even targets.
- Stall (En=0):
  - No state changes.
  - Combinational outputs still reflect current inputs.
- HLT with En=0: no transition; it retires when En returns to 1.

Test Plan:
- Reset and sequential fetch:
  - rst=1 one cycle, then En=1, Opcode=ADD with ALU_Result nonzero.
  - PC_out=0000, then 0002, 0004; Flags_q=000 during reset; Halted=0.
- Flag capture and selective update:
  - SUB with ALU_Result=0000, Flags_in=010 -> Flags_q=011.
  - Then XOR with ALU_Result=8001 -> Flags_q=010; N and V held.
  - Then LW -> flags unchanged.
- Condition evaluation:
  - With Flags_q=100 (N=1), issue B at PC=0010, Imm9=9'h1FC (-4) for each Cond.
  - LT, LE, NE and UNCOND are taken: PC=0012-8=000A.
  - EQ, GT, GE and OV are not taken: PC=0012.
- BR and wrap-around:
  - BR Cond=111, Reg_Target=1234 -> PC=1234.
  - From PC=FFFE, a non-branch -> PC=0000.
  - From PC=FFFC, B Cond=111, Imm9=9'h002 -> PC=0002.
- Stall and halt:
  - En=0 for 3 cycles with Opcode=ADD -> PC and flags frozen.
  - HLT at PC=0020 with En=1 -> Halted=1, PC stays 0020 for 10+ cycles under random opcodes.
  - rst -> PC=RESET_PC, Halted=0.
- Same-cycle ordering:
  - SUB producing Z=1 immediately followed by B EQ: the branch uses the new Flags_q and is taken.
  - A branch in the same cycle as ADD is impossible, so verify the branch never sees ALU_Result: drive a B with ALU_Result=0000 while Flags_q.Z=0, Cond=EQ -> not taken.
